pc_sequencer: RTL and testbench

//  Parametrised program-address sequencer for the flow-control processor. Generates
//  the instruction-ROM address each clock. Adds relative-free absolute jump, call/return
//  via a hardware return stack, and an internal delay counter (no external count_done).

---
 rtl/pc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-address sequencer: increment, absolute jump, call/return through a
// small hardware return stack, and an internal delay counter that parks the
// pc for a programmable number of cycles.
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int DELAY_W     = 16,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pchalt,
  input  logic              step_en,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  input  logic              delay_req,
  input  logic [DELAY_W-1:0] delay_cycles,
  input  logic              fault_clr,
  output logic [ADDR_W-1:0] pcout,
  output logic              waiting,
  output logic              delay_done,
  output logic [SP_W-1:0]   sp,
  output logic              stack_ovf,
  output logic              stack_unf,
  output logic              fault
);

  // Stack index only needs to address STACK_DEPTH entries; memory is rounded
  // up to a power of two so any IDX_W-bit index stays in range.
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc_n;
  logic [SP_W-1:0]     sp_n;
  logic [DELAY_W-1:0]  cnt, cnt_n;
  logic                ovf_n, unf_n, done_n;
  logic                push_en;
  logic [ADDR_W-1:0]   push_addr;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    pop_idx;
  logic [ADDR_W-1:0]   stack_mem [2**IDX_W];

  // Program address increment, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  assign push_addr = addr_inc(pcout);
  assign push_idx  = sp[IDX_W-1:0];
  assign pop_idx   = IDX_W'(sp - SP_ONE);

  // Next-state, next-pc, stack pointer and flag logic.
  always_comb begin
    state_n = state;
    pc_n    = pcout;
    sp_n    = sp;
    cnt_n   = cnt;
    ovf_n   = stack_ovf;
    unf_n   = stack_unf;
    done_n  = 1'b0;
    push_en = 1'b0;
    if (pchalt) begin
      state_n = RUN;
      pc_n    = '0;
      sp_n    = '0;
      cnt_n   = '0;
      ovf_n   = 1'b0;
      unf_n   = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (step_en) begin
            if (jump) begin
              pc_n = target;
            end else if (call) begin
              if (sp < SP_FULL) begin
                push_en = 1'b1;
                sp_n    = sp + SP_ONE;
                pc_n    = target;
              end else begin
                ovf_n   = 1'b1;
                state_n = FAULT;
              end
            end else if (ret) begin
              if (sp != '0) begin
                sp_n = sp - SP_ONE;
                pc_n = stack_mem[pop_idx];
              end else begin
                unf_n   = 1'b1;
                state_n = FAULT;
              end
            end else if (delay_req && (delay_cycles != '0)) begin
              cnt_n   = delay_cycles - DELAY_W'(1);
              state_n = WAIT;
            end else begin
              pc_n = addr_inc(pcout);
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt_n = cnt - DELAY_W'(1);
          end else begin
            pc_n    = addr_inc(pcout);
            done_n  = 1'b1;
            state_n = RUN;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            ovf_n   = 1'b0;
            unf_n   = 1'b0;
            pc_n    = addr_inc(pcout);
            state_n = RUN;
          end
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

  // Control and status registers; waiting/fault are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      pcout      <= '0;
      sp         <= '0;
      cnt        <= '0;
      stack_ovf  <= 1'b0;
      stack_unf  <= 1'b0;
      delay_done <= 1'b0;
      waiting    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      pcout      <= pc_n;
      sp         <= sp_n;
      cnt        <= cnt_n;
      stack_ovf  <= ovf_n;
      stack_unf  <= unf_n;
      delay_done <= done_n;
      waiting    <= (state_n == WAIT);
      fault      <= (state_n == FAULT);
    end
  end

  // Return-stack storage; contents are don't-care once popped, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= push_addr;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  localparam int ADDR_W = 8;
  localparam int DELAY_W = 16;
  localparam int STACK_DEPTH = 4;
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n, pchalt, step_en, jump, call, ret, delay_req, fault_clr;
  logic [ADDR_W-1:0] target;
  logic [DELAY_W-1:0] delay_cycles;
  logic [ADDR_W-1:0] pcout;
  logic waiting, delay_done, stack_ovf, stack_unf, fault;
  logic [SP_W-1:0] sp;

  int n_total = 0;
  int n_bad = 0;

  pc_sequencer #(.ADDR_W(ADDR_W), .DELAY_W(DELAY_W), .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pchalt(pchalt), .step_en(step_en), .jump(jump),
    .call(call), .ret(ret), .target(target), .delay_req(delay_req),
    .delay_cycles(delay_cycles), .fault_clr(fault_clr), .pcout(pcout),
    .waiting(waiting), .delay_done(delay_done), .sp(sp), .stack_ovf(stack_ovf),
    .stack_unf(stack_unf), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are sampled on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    jump = 0; call = 0; ret = 0; delay_req = 0; fault_clr = 0; pchalt = 0;
  endtask

  task automatic do_jump(input int t);
    idle(); jump = 1; target = ADDR_W'(t); step(); idle();
  endtask

  task automatic do_call(input int t);
    idle(); call = 1; target = ADDR_W'(t); step(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1; step(); idle();
  endtask

  initial begin
    rst_n = 0; step_en = 0; target = '0; delay_cycles = '0;
    idle();
    step(); step();
    rst_n = 1; step_en = 1;
    step(); step(); step();
    chk("pre_reset_pc", pcout, 3);

    // T1: asynchronous reset mid-cycle, then free run to the wrap point
    #3 rst_n = 0;
    #1;
    chk("rst_pc", pcout, 0);
    chk("rst_sp", sp, 0);
    chk("rst_flags", {stack_ovf, stack_unf, fault, waiting, delay_done}, 0);
    step();
    rst_n = 1;
    chk("rst_hold_pc", pcout, 0);
    for (int i = 0; i < 255; i++) step();
    chk("inc_255", pcout, 255);
    step();
    chk("inc_wrap", pcout, 0);

    // T2: delay N=3 holds pc=5 for 4 cycles then pulses delay_done
    do_jump(5);
    chk("jump5", pcout, 5);
    delay_req = 1; delay_cycles = 3;
    step(); idle();
    chk("dly_e0_pc", pcout, 5);
    chk("dly_e0_wait", waiting, 1);
    step();
    chk("dly_e1_pc", pcout, 5);
    step();
    chk("dly_e2_pc", pcout, 5);
    chk("dly_e2_done", delay_done, 0);
    step();
    chk("dly_e3_pc", pcout, 6);
    chk("dly_e3_done", delay_done, 1);
    chk("dly_e3_wait", waiting, 0);
    step();
    chk("dly_e4_done", delay_done, 0);
    chk("dly_e4_pc", pcout, 7);
    do_jump(5);
    delay_req = 1; delay_cycles = 0;
    step(); idle();
    chk("dly0_pc", pcout, 6);
    chk("dly0_wait", waiting, 0);

    // T3: call/return and nested calls
    do_jump(10);
    do_call(40);
    chk("call_pc", pcout, 40);
    chk("call_sp", sp, 1);
    step();
    chk("call_next", pcout, 41);
    do_ret();
    chk("ret_pc", pcout, 11);
    chk("ret_sp", sp, 0);
    do_call(100);
    do_call(110);
    do_call(120);
    do_call(130);
    chk("nest_pc", pcout, 130);
    chk("nest_sp", sp, 4);

    // T4: overflow on the fifth call, then recovery via fault_clr
    do_call(200);
    chk("ovf_pc", pcout, 130);
    chk("ovf_flag", stack_ovf, 1);
    chk("ovf_fault", fault, 1);
    chk("ovf_sp", sp, 4);
    jump = 1; target = 8'd99; step(); idle();
    chk("fault_hold_pc", pcout, 130);
    fault_clr = 1; step(); idle();
    chk("clr_pc", pcout, 131);
    chk("clr_flags", {stack_ovf, fault}, 0);
    do_ret();
    chk("pop4", pcout, 121);
    do_ret();
    chk("pop3", pcout, 111);
    do_ret();
    chk("pop2", pcout, 101);
    do_ret();
    chk("pop1", pcout, 12);
    chk("pop_sp", sp, 0);

    // T5: underflow, then pchalt clears everything
    do_ret();
    chk("unf_pc", pcout, 12);
    chk("unf_flag", stack_unf, 1);
    chk("unf_fault", fault, 1);
    pchalt = 1; step(); idle();
    chk("halt_pc", pcout, 0);
    chk("halt_flags", {stack_ovf, stack_unf, fault}, 0);
    chk("halt_sp", sp, 0);

    // Pushed return address wraps from all-ones to zero
    do_jump(255);
    do_call(3);
    do_ret();
    chk("ret_wrap", pcout, 0);

    // T6: priority, stall, and pchalt aborting a long delay
    jump = 1; call = 1; delay_req = 1; delay_cycles = 5; target = 77;
    step(); idle();
    chk("prio_pc", pcout, 77);
    chk("prio_sp", sp, 0);
    chk("prio_wait", waiting, 0);
    step_en = 0; jump = 1; target = 8'd20;
    step(); step(); idle();
    chk("stall_pc", pcout, 77);
    step_en = 1; delay_req = 1; delay_cycles = 100;
    step(); idle();
    chk("long_wait", waiting, 1);
    step(); step(); step();
    chk("long_pc", pcout, 77);
    pchalt = 1; step(); idle();
    chk("abort_pc", pcout, 0);
    chk("abort_wait", waiting, 0);
    chk("abort_done", delay_done, 0);
    step();
    chk("abort_after_done", delay_done, 0);
    chk("abort_after_pc", pcout, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
